// File: rtl/vm1_fetch_seq.sv
// Instruction fetch/dispatch sequencer: fetches a word at pc, lets the decoder
// settle, classifies the instruction and hands it to the execution unit.
module vm1_fetch_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [15:0] pc,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    input  logic        bus_ack,
    input  logic [15:0] bus_din,
    output logic [15:0] ir,
    input  logic        cls_unused,
    input  logic        cls_nof,
    input  logic        cls_bra,
    input  logic        cls_cco,
    input  logic        cls_rsd,
    input  logic        cls_one,
    input  logic        cls_two,
    output logic        pc_inc,
    output logic        disp_valid,
    output logic [2:0]  disp_class,
    input  logic        disp_ready,
    input  logic        exec_done,
    input  logic        irq_pend,
    output logic        irq_take,
    output logic        trap_ill,
    output logic        trap_bus
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CLS_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CLS_W-1:0] CLS_ILL = CLS_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_EXEC
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
    logic               irq_held, irq_held_d;
    logic [ADDR_W-1:0]  bus_addr_d;
    logic               bus_rd_d;
    logic [DATA_W-1:0]  ir_d;
    logic               pc_inc_d;
    logic               disp_valid_d;
    logic [CLS_W-1:0]   disp_class_d;
    logic               irq_take_d;
    logic               trap_ill_d;
    logic               trap_bus_d;
    logic [CLS_W-1:0]   cls_code;

    // Class priority: first true flag wins, none true means illegal.
    always_comb begin
        cls_code = CLS_ILL;
        if (cls_nof)      cls_code = CLS_W'(1);
        else if (cls_bra) cls_code = CLS_W'(2);
        else if (cls_cco) cls_code = CLS_W'(3);
        else if (cls_rsd) cls_code = CLS_W'(4);
        else if (cls_one) cls_code = CLS_W'(5);
        else if (cls_two) cls_code = CLS_W'(6);
    end

    // Saturating no-ack counter increment.
    assign cnt_inc = (cnt >= TMO) ? cnt : cnt + CNT_W'(1);

    // Next state and next registered outputs.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        irq_held_d   = irq_held & irq_pend;
        bus_addr_d   = bus_addr;
        bus_rd_d     = bus_rd;
        ir_d         = ir;
        pc_inc_d     = 1'b0;
        disp_valid_d = disp_valid;
        disp_class_d = disp_class;
        irq_take_d   = 1'b0;
        trap_ill_d   = 1'b0;
        trap_bus_d   = 1'b0;

        case (state)
            S_IDLE: begin
                // A held request is granted once; it keeps blocking fetch until dropped.
                if (irq_pend) begin
                    if (!irq_held) begin
                        irq_take_d = 1'b1;
                        irq_held_d = 1'b1;
                    end
                end else if (run) begin
                    state_d    = S_FETCH;
                    bus_addr_d = pc;
                    bus_rd_d   = 1'b1;
                    cnt_d      = '0;
                end
            end
            S_FETCH: begin
                if (bus_ack) begin
                    ir_d     = bus_din;
                    pc_inc_d = 1'b1;
                    bus_rd_d = 1'b0;
                    state_d  = S_DECODE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TMO) begin
                        bus_rd_d   = 1'b0;
                        trap_bus_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_DECODE: begin
                if (cls_unused || (cls_code == CLS_ILL)) begin
                    trap_ill_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    disp_class_d = cls_code;
                    disp_valid_d = 1'b1;
                    state_d      = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (disp_ready) begin
                    disp_valid_d = 1'b0;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            irq_held   <= 1'b0;
            bus_addr   <= '0;
            bus_rd     <= 1'b0;
            ir         <= '0;
            pc_inc     <= 1'b0;
            disp_valid <= 1'b0;
            disp_class <= '0;
            irq_take   <= 1'b0;
            trap_ill   <= 1'b0;
            trap_bus   <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            irq_held   <= irq_held_d;
            bus_addr   <= bus_addr_d;
            bus_rd     <= bus_rd_d;
            ir         <= ir_d;
            pc_inc     <= pc_inc_d;
            disp_valid <= disp_valid_d;
            disp_class <= disp_class_d;
            irq_take   <= irq_take_d;
            trap_ill   <= trap_ill_d;
            trap_bus   <= trap_bus_d;
        end
    end

endmodule

// File: tb/tb_vm1_fetch_seq.sv
// Directed bench for vm1_fetch_seq: expected ir/class pushed to a scoreboard
// when a fetch is answered, popped when the sequencer dispatches or traps.
module tb_vm1_fetch_seq;

    localparam int unsigned TMO = 15;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  cls;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic [15:0] pc;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_ack;
    logic [15:0] bus_din;
    logic [15:0] ir;
    logic        cls_unused, cls_nof, cls_bra, cls_cco, cls_rsd, cls_one, cls_two;
    logic        pc_inc;
    logic        disp_valid;
    logic [2:0]  disp_class;
    logic        disp_ready;
    logic        exec_done;
    logic        irq_pend;
    logic        irq_take;
    logic        trap_ill;
    logic        trap_bus;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          pc_inc_seen = 0;
    int          fetch_ok = 0;
    logic [15:0] last_ir = '0;

    vm1_fetch_seq #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .pc         (pc),
        .bus_addr   (bus_addr),
        .bus_rd     (bus_rd),
        .bus_ack    (bus_ack),
        .bus_din    (bus_din),
        .ir         (ir),
        .cls_unused (cls_unused),
        .cls_nof    (cls_nof),
        .cls_bra    (cls_bra),
        .cls_cco    (cls_cco),
        .cls_rsd    (cls_rsd),
        .cls_one    (cls_one),
        .cls_two    (cls_two),
        .pc_inc     (pc_inc),
        .disp_valid (disp_valid),
        .disp_class (disp_class),
        .disp_ready (disp_ready),
        .exec_done  (exec_done),
        .irq_pend   (irq_pend),
        .irq_take   (irq_take),
        .trap_ill   (trap_ill),
        .trap_bus   (trap_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {unused, nof, bra, cco, rsd, one, two}.
    function automatic logic [2:0] model_cls(input logic [6:0] f);
        if (f[6]) return 3'd7;
        for (int i = 5; i >= 0; i--)
            if (f[i]) return 3'(6 - i);
        return 3'd7;
    endfunction

    task automatic set_cls(input logic [6:0] f);
        {cls_unused, cls_nof, cls_bra, cls_cco, cls_rsd, cls_one, cls_two} = f;
    endtask

    task automatic start_fetch(input logic [15:0] a);
        pc  = a;
        run = 1'b1;
        step();
        run = 1'b0;
        pc  = 16'hffff;
        chk("fetch_rd", 32'(bus_rd), 1);
        chk("fetch_addr", 32'(bus_addr), 32'(a));
    endtask

    task automatic complete_instr(input logic [15:0] a, input logic [15:0] d,
                                  input logic [6:0] f, input int ack_wait, input int rdy_wait);
        exp_t e;
        sb.push_back('{ir: d, cls: model_cls(f)});
        repeat (ack_wait) begin
            step();
            chk("rd_hold", 32'(bus_rd), 1);
            chk("addr_hold", 32'(bus_addr), 32'(a));
        end
        bus_ack = 1'b1;
        bus_din = d;
        set_cls(f);
        step();
        bus_ack = 1'b0;
        bus_din = 16'($urandom);
        chk("pc_inc", 32'(pc_inc), 1);
        chk("rd_drop", 32'(bus_rd), 0);
        fetch_ok++;
        last_ir = d;
        step();
        set_cls(7'b0);
        e = sb.pop_front();
        chk("pc_inc_end", 32'(pc_inc), 0);
        chk("ir_load", 32'(ir), 32'(e.ir));
        if (e.cls == 3'd7) begin
            chk("trap_ill", 32'(trap_ill), 1);
            chk("no_disp", 32'(disp_valid), 0);
            step();
            chk("trap_ill_end", 32'(trap_ill), 0);
            chk("trap_idle_rd", 32'(bus_rd), 0);
        end else begin
            chk("disp_valid", 32'(disp_valid), 1);
            chk("disp_class", 32'(disp_class), 32'(e.cls));
            repeat (rdy_wait) begin
                step();
                chk("disp_hold_v", 32'(disp_valid), 1);
                chk("disp_hold_c", 32'(disp_class), 32'(e.cls));
            end
            disp_ready = 1'b1;
            step();
            disp_ready = 1'b0;
            chk("disp_done", 32'(disp_valid), 0);
            step();
            exec_done = 1'b1;
            step();
            exec_done = 1'b0;
            chk("exec_idle_rd", 32'(bus_rd), 0);
        end
    endtask

    // Pulse outputs must be mutually exclusive; count pc_inc cycles.
    always @(negedge clk) begin
        if (pc_inc) pc_inc_seen++;
        chk("pulse_excl", 32'($countones({pc_inc, irq_take, trap_ill, trap_bus}) <= 1), 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; run = 1'b0; pc = '0; bus_ack = 1'b0; bus_din = '0;
        set_cls(7'b0); disp_ready = 1'b0; exec_done = 1'b0; irq_pend = 1'b0;
        repeat (3) step();
        chk("rst_rd", 32'(bus_rd), 0);
        chk("rst_addr", 32'(bus_addr), 0);
        chk("rst_ir", 32'(ir), 0);
        chk("rst_dv", 32'(disp_valid), 0);
        chk("rst_dc", 32'(disp_class), 0);
        chk("rst_pulses", 32'({pc_inc, irq_take, trap_ill, trap_bus}), 0);
        reset_n = 1'b1;
        repeat (3) step();
        chk("no_run_rd", 32'(bus_rd), 0);

        start_fetch(16'o1000);
        complete_instr(16'o1000, 16'o010203, 7'b0000001, 3, 0);
        start_fetch(16'o1002);
        complete_instr(16'o1002, 16'o000010, 7'b1000000, 1, 0);
        start_fetch(16'o1004);
        complete_instr(16'o1004, 16'o012345, 7'b0000000, 0, 0);
        start_fetch(16'o1006);
        complete_instr(16'o1006, 16'o000401, 7'b0010001, 0, 5);
        start_fetch(16'o1010);
        complete_instr(16'o1010, 16'o000240, 7'b0001110, 2, 1);
        start_fetch(16'o1012);
        complete_instr(16'o1012, 16'o000207, 7'b0000100, 0, 0);
        // Ack lands on the last cycle before timeout: fetch must succeed.
        start_fetch(16'o1014);
        complete_instr(16'o1014, 16'o000100, 7'b0100000, TMO - 1, 2);

        // Bus timeout: bus_rd held TMO cycles, then one trap_bus pulse.
        start_fetch(16'o2000);
        repeat (TMO - 1) begin
            step();
            chk("tmo_rd", 32'(bus_rd), 1);
            chk("tmo_early", 32'(trap_bus), 0);
        end
        step();
        chk("tmo_rd_drop", 32'(bus_rd), 0);
        chk("tmo_trap", 32'(trap_bus), 1);
        chk("tmo_ir", 32'(ir), 32'(last_ir));
        step();
        chk("tmo_trap_end", 32'(trap_bus), 0);
        chk("tmo_idle_rd", 32'(bus_rd), 0);

        // Interrupt at the instruction boundary beats run.
        start_fetch(16'o1016);
        complete_instr(16'o1016, 16'o005001, 7'b0000010, 0, 0);
        pc = 16'o1100;
        irq_pend = 1'b1;
        run = 1'b1;
        step();
        chk("irq_take", 32'(irq_take), 1);
        chk("irq_no_rd", 32'(bus_rd), 0);
        step();
        chk("irq_take_end", 32'(irq_take), 0);
        chk("irq_hold_rd", 32'(bus_rd), 0);
        irq_pend = 1'b0;
        step();
        run = 1'b0;
        chk("irq_fetch_rd", 32'(bus_rd), 1);
        chk("irq_fetch_addr", 32'(bus_addr), 32'(16'o1100));
        complete_instr(16'o1100, 16'o010001, 7'b0000001, 1, 0);

        // Reset during FETCH with ack pending in the same cycle.
        start_fetch(16'o3000);
        bus_ack = 1'b1;
        bus_din = 16'o123456;
        set_cls(7'b0100000);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_rd", 32'(bus_rd), 0);
        chk("arst_ir", 32'(ir), 0);
        chk("arst_addr", 32'(bus_addr), 0);
        step();
        chk("arst_pc_inc", 32'(pc_inc), 0);
        chk("arst_ir_hold", 32'(ir), 0);
        chk("arst_outs", 32'({disp_valid, disp_class, irq_take, trap_ill, trap_bus}), 0);
        bus_ack = 1'b0;
        set_cls(7'b0);
        reset_n = 1'b1;
        step();
        chk("post_rst_rd", 32'(bus_rd), 0);
        start_fetch(16'o4000);
        complete_instr(16'o4000, 16'o000777, 7'b0001000, 0, 0);

        step();
        chk("pc_inc_count", 32'(pc_inc_seen), 32'(fetch_ok));
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vm1_fetch_seq.md
VM1_FETCH_SEQ -- requirements
Module: vm1_fetch_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the bus-ack wait limit in clk cycles (4-bit).
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port run, input, 1: when high, the sequencer may start new fetches.
REQ-005 SHALL have port pc, input, 16: the current PC, sampled on FETCH entry.
REQ-006 SHALL have port bus_addr, output, 16: the fetch address, held stable while bus_rd is high.
REQ-007 SHALL have port bus_rd, output, 1: the word read request.
REQ-008 SHALL have port bus_ack, input, 1: read data is valid this cycle.
REQ-009 SHALL have port bus_din, input, 16: the read data.
REQ-010 SHALL have port ir, output, 16: the instruction register, driven to the decoder opcode input.
REQ-011 SHALL have ports cls_unused, cls_nof, cls_bra, cls_cco, cls_rsd, cls_one, cls_two, input, 1 each: decoder class flags for ir (cls_one = one-operand/JMP/JSR class; cls_two = two-operand class).
REQ-012 SHALL have port pc_inc, output, 1: a one-cycle pulse requesting PC += 2.
REQ-013 SHALL have port disp_valid, output, 1: the dispatch is offered to the execution unit.
REQ-014 SHALL have port disp_class, output, 3: the dispatch class code.
REQ-015 SHALL have port disp_ready, input, 1: the execution unit accepts the dispatch.
REQ-016 SHALL have port exec_done, input, 1: a one-cycle pulse marking the end of the current instruction.
REQ-017 SHALL have port irq_pend, input, 1: an interrupt request, sampled only at an instruction boundary.
REQ-018 SHALL have port irq_take, output, 1: a one-cycle pulse granting the interrupt.
REQ-019 SHALL have port trap_ill, output, 1: a one-cycle pulse for a reserved instruction (vector 010).
REQ-020 SHALL have port trap_bus, output, 1: a one-cycle pulse for a fetch timeout (vector 004).

Function
REQ-021 SHALL implement the states IDLE, FETCH, DECODE, DISPATCH and EXEC, encoded one-hot or binary.
REQ-022 IDLE transitions:
- irq_pend=1 -> pulse irq_take, stay in IDLE.
- Otherwise run=1 -> FETCH.
- irq_pend has priority over run.
REQ-023 On FETCH entry, SHALL latch pc into bus_addr and assert bus_rd in the same cycle as the FETCH state.
REQ-024 In FETCH, on bus_ack=1: load ir<=bus_din, pulse pc_inc, deassert bus_rd next cycle, go to DECODE.
REQ-025 In FETCH, SHALL count bus_rd cycles without ack; when the count reaches TIMEOUT with no ack, it SHALL deassert bus_rd, pulse trap_bus and return to IDLE, leaving ir unchanged.
REQ-026 bus_ack in the same cycle as the count reaching TIMEOUT SHALL count as success (ack wins).
REQ-027 DECODE SHALL last exactly one cycle, allowing the combinational decoder to settle.
REQ-028 The class SHALL be registered at the end of DECODE using this priority:
- cls_unused -> trap_ill pulse, go to IDLE.
- Else the first true of nof=1, bra=2, cco=3, rsd=4, one=5, two=6.
- None true -> 7 (illegal), treated as cls_unused.
REQ-029 DISPATCH SHALL hold disp_valid=1 with disp_class stable until disp_ready=1; then go to EXEC with disp_valid=0 the next cycle.
REQ-030 EXEC SHALL wait for exec_done, then go to IDLE; fetch latency from exec_done to the next bus_rd is 2 cycles (IDLE, FETCH).
REQ-031 run=0 SHALL only inhibit leaving IDLE; an in-flight fetch, dispatch or exec SHALL complete.
REQ-032 pc_inc, irq_take, trap_ill and trap_bus SHALL never be asserted in the same cycle, and each pulse SHALL last exactly 1 cycle.
REQ-033 The timeout counter SHALL saturate and never wrap, and SHALL clear on every FETCH entry.

Reset
REQ-034 When reset_n=0, the block SHALL asynchronously enter IDLE and set ir=0, bus_addr=0, counter=0 and all outputs low; disp_class shall be 0.
REQ-035 A reset asserted mid-FETCH SHALL drop bus_rd immediately, with no pulses generated.
REQ-036 After reset deassertion, the first fetch SHALL occur only when run=1, starting with bus_rd on the second rising edge.

Verification
REQ-037 run=1, pc=0o1000, ack after 3 cycles with din=0o010203 and cls_two -> bus_addr=0o1000, ir=0o010203, one pc_inc pulse, disp_class=6.
REQ-038 No ack for TIMEOUT cycles -> exactly one trap_bus pulse, bus_rd low, state IDLE, ir unchanged.
REQ-039 din=0o000010 with cls_unused=1 -> trap_ill pulse one cycle after DECODE, no disp_valid.
REQ-040 disp_ready held low for 5 cycles -> disp_valid and disp_class stable for all 5; then handshake completes and disp_valid is low on the next cycle.
REQ-041 irq_pend=1 and run=1 at an instruction boundary after exec_done -> irq_take pulses and no bus_rd that cycle; once irq_pend=0, a fetch starts.
REQ-042 reset_n pulsed low during FETCH with ack in the same cycle -> ir=0, no pc_inc, all outputs 0.
